// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
//   size_e       : access size codes as seen on req*_size / mem_size
//   lock_state_e : states of the optional requester lock
//   bytes()      : byte count of a size code (0 for illegal codes)
//   load_extend(): zero/sign extension of raw little-endian load data
//   ERR_DATA     : load data returned for a rejected request
package dmem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BS = 3'b100,
    SZ_HS = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    StUnlocked = 2'd0,
    StLock0    = 2'd1,
    StLock1    = 2'd2
  } lock_state_e;

  localparam logic [31:0] ERR_DATA = 32'hDEADC0DE;

  function automatic logic [2:0] bytes(input logic [2:0] size);
    case (size)
      SZ_B, SZ_BS: bytes = 3'd1;
      SZ_H, SZ_HS: bytes = 3'd2;
      SZ_W:        bytes = 3'd4;
      default:     bytes = 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [31:0] raw);
    case (size)
      SZ_B:    load_extend = {24'h0, raw[7:0]};
      SZ_H:    load_extend = {16'h0, raw[15:0]};
      SZ_BS:   load_extend = {{24{raw[7]}}, raw[7:0]};
      SZ_HS:   load_extend = {{16{raw[15]}}, raw[15:0]};
      default: load_extend = raw;
    endcase
  endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Combinational legality check for one requester.
//   addr : byte address of the request
//   size : size code
//   wen  : 1 = store
//   err  : 1 when the size code is illegal (or a signed store) or the access
//          runs past the end of memory
module dmem_req_check import dmem_pkg::*; #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic        wen,
  output logic        err
);

  logic [2:0]  nbytes;
  logic        size_ok;
  logic [32:0] last_byte;

  always_comb begin
    nbytes    = bytes(size);
    size_ok   = (nbytes != 3'd0) && !(wen && size[2]);
    // 33-bit sum so an address near 2^32 cannot wrap back into range
    last_byte = {1'b0, addr} + {30'd0, nbytes} - 33'd1;
    err       = !size_ok || (last_byte >= 33'(MEM_BYTES));
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported data memory.
// Port 0 is the load/store unit, port 1 the loader/DMA. At most one access is
// granted per cycle (round-robin on ties); its response is registered and
// pulses for one cycle on the granted port's rsp* outputs.
//   req0_* / req1_* : valid/ready request handshake, addr, size, wen, wdata, lock
//   rsp0_* / rsp1_* : registered response valid, rdata, err
//   mem_*           : memory address, size, write data/enable, read data
// Optional feature: define DMEM_ARB_LOCK_EN to let a requester hold the
// memory across several accesses via req*_lock; otherwise req*_lock is ignored.
module dmem_arbiter import dmem_pkg::*; #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  input  logic [2:0]  req0_size,
  input  logic        req0_wen,
  input  logic [31:0] req0_wdata,
  input  logic        req0_lock,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_addr,
  input  logic [2:0]  req1_size,
  input  logic        req1_wen,
  input  logic [31:0] req1_wdata,
  input  logic        req1_lock,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_wData,
  output logic        mem_wEn,
  input  logic [31:0] mem_rData
);

  logic        err0, err1;
  logic        elig0, elig1, gnt0, gnt1, accept;
  logic        sel_err, sel_wen, sel_lock;
  logic [31:0] rsp_data;
  logic        last_grant_q;  // 1 = port 1 was granted last
  logic        rsp0_valid_q, rsp0_err_q, rsp1_valid_q, rsp1_err_q;
  logic [31:0] rsp0_rdata_q, rsp1_rdata_q;
  lock_state_e lock_q;

  dmem_req_check #(.MEM_BYTES(MEM_BYTES)) u_check0 (
    .addr (req0_addr),
    .size (req0_size),
    .wen  (req0_wen),
    .err  (err0)
  );

  dmem_req_check #(.MEM_BYTES(MEM_BYTES)) u_check1 (
    .addr (req1_addr),
    .size (req1_size),
    .wen  (req1_wen),
    .err  (err1)
  );

  // Grant: a lock excludes the other port even while the owner is idle.
  always_comb begin
    elig0  = req0_valid & ~rst & (lock_q != StLock1);
    elig1  = req1_valid & ~rst & (lock_q != StLock0);
    gnt0   = elig0 & (~elig1 | last_grant_q);
    gnt1   = elig1 & (~elig0 | ~last_grant_q);
    accept = gnt0 | gnt1;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    mem_addr  = '0;
    mem_size  = '0;
    mem_wData = '0;
    sel_err   = 1'b0;
    sel_wen   = 1'b0;
    sel_lock  = 1'b0;
    if (gnt1) begin
      mem_addr  = req1_addr;
      mem_size  = req1_size;
      mem_wData = req1_wdata;
      sel_err   = err1;
      sel_wen   = req1_wen;
      sel_lock  = req1_lock;
    end else if (gnt0) begin
      mem_addr  = req0_addr;
      mem_size  = req0_size;
      mem_wData = req0_wdata;
      sel_err   = err0;
      sel_wen   = req0_wen;
      sel_lock  = req0_lock;
    end
    // A rejected access must never reach the memory as a write.
    mem_wEn  = accept & sel_wen & ~sel_err;
    rsp_data = sel_err ? ERR_DATA : (sel_wen ? 32'h0 : load_extend(mem_size, mem_rData));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp1_rdata_q <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rsp0_valid_q <= gnt0;
      rsp0_err_q   <= gnt0 & sel_err;
      rsp0_rdata_q <= gnt0 ? rsp_data : 32'h0;
      rsp1_valid_q <= gnt1;
      rsp1_err_q   <= gnt1 & sel_err;
      rsp1_rdata_q <= gnt1 ? rsp_data : 32'h0;
      if (accept) last_grant_q <= gnt1;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_err   = rsp1_err_q;
  assign rsp1_rdata = rsp1_rdata_q;

`ifdef DMEM_ARB_LOCK_EN
  lock_state_e lock_d;

  // Errored requests still move the lock: the requester asked for it.
  always_comb begin
    lock_d = lock_q;
    unique case (lock_q)
      StUnlocked: if (accept && sel_lock) lock_d = gnt1 ? StLock1 : StLock0;
      StLock0:    if (gnt0 && !req0_lock) lock_d = StUnlocked;
      StLock1:    if (gnt1 && !req1_lock) lock_d = StUnlocked;
      default:    lock_d = StUnlocked;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_q <= StUnlocked;
    else     lock_q <= lock_d;
  end
`else
  logic lock_unused;
  assign lock_q      = StUnlocked;
  assign lock_unused = sel_lock ^ req0_lock ^ req1_lock;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int unsigned MEM_BYTES = 4096;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic        lock;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  req_t        r0, r1;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] mem_addr, mem_wData, mem_rData;
  logic [2:0]  mem_size;
  logic        mem_wEn;

  logic [7:0] mem     [MEM_BYTES];  // memory seen by the DUT
  logic [7:0] ref_mem [MEM_BYTES];  // model's idea of memory contents

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_last;
  int          m_lock;  // 0 none, 1 port 0 owns, 2 port 1 owns
  bit          exp_v [2];
  bit          exp_e [2];
  logic [31:0] exp_d [2];
  logic        last_ready0, last_ready1;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (r0.valid),
    .req0_ready (req0_ready),
    .req0_addr  (r0.addr),
    .req0_size  (r0.size),
    .req0_wen   (r0.wen),
    .req0_wdata (r0.wdata),
    .req0_lock  (r0.lock),
    .req1_valid (r1.valid),
    .req1_ready (req1_ready),
    .req1_addr  (r1.addr),
    .req1_size  (r1.size),
    .req1_wen   (r1.wen),
    .req1_wdata (r1.wdata),
    .req1_lock  (r1.lock),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp0_err   (rsp0_err),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .rsp1_err   (rsp1_err),
    .mem_addr   (mem_addr),
    .mem_size   (mem_size),
    .mem_wData  (mem_wData),
    .mem_wEn    (mem_wEn),
    .mem_rData  (mem_rData)
  );

  function automatic int nbytes_of(logic [2:0] s);
    case (s)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit in_range(logic [31:0] a, int i);
    longint unsigned x;
    x = longint'(a) + longint'(i);
    return x < longint'(MEM_BYTES);
  endfunction

  // Memory: raw little-endian read of four bytes, byte-wise write.
  always_comb begin
    mem_rData = '0;
    for (int i = 0; i < 4; i++)
      if (in_range(mem_addr, i)) mem_rData[8*i +: 8] = mem[mem_addr + 32'(i)];
  end

  always @(posedge clk) begin
    if (mem_wEn)
      for (int i = 0; i < nbytes_of(mem_size); i++)
        if (in_range(mem_addr, i)) mem[mem_addr + 32'(i)] = mem_wData[8*i +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic req_t mk(logic v, logic [31:0] a, logic [2:0] s, logic w,
                              logic [31:0] d, logic l);
    req_t r;
    r.valid = v;
    r.addr  = a;
    r.size  = s;
    r.wen   = w;
    r.wdata = d;
    r.lock  = l;
    return r;
  endfunction

  function automatic bit legal(req_t r);
    int n;
    n = nbytes_of(r.size);
    if (n == 0) return 0;
    if (r.wen && r.size[2]) return 0;
    return in_range(r.addr, n - 1);
  endfunction

  function automatic logic [31:0] ref_load(req_t r);
    int     n;
    longint v;
    n = nbytes_of(r.size);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[r.addr + 32'(i)]) << (8 * i);
    if (r.size[2] && v >= (64'sd1 << (8 * n - 1))) v -= (64'sd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic int model_grant();
    bit e0, e1;
    e0 = r0.valid && (m_lock != 2);
    e1 = r1.valid && (m_lock != 1);
    if (e0 && e1) return (m_last == 0) ? 1 : 0;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic void model_commit(int g);
    req_t s;
    exp_v[0] = 0;
    exp_v[1] = 0;
    if (g < 0) return;
    s = (g == 1) ? r1 : r0;
    exp_v[g] = 1;
    exp_e[g] = !legal(s);
    if (!legal(s)) exp_d[g] = 32'hDEADC0DE;
    else if (s.wen) begin
      exp_d[g] = 32'h0;
      for (int i = 0; i < nbytes_of(s.size); i++) ref_mem[s.addr + 32'(i)] = s.wdata[8*i +: 8];
    end else exp_d[g] = ref_load(s);
    m_last = g;
`ifdef DMEM_ARB_LOCK_EN
    if (m_lock == 0 && s.lock) m_lock = g + 1;
    else if (m_lock == g + 1 && !s.lock) m_lock = 0;
`endif
  endfunction

  function automatic void model_reset();
    m_last   = 1;
    m_lock   = 0;
    exp_v[0] = 0;
    exp_v[1] = 0;
  endfunction

  // One cycle: inputs are already applied; check at the falling edge, then advance.
  task automatic step(output int g);
    int   gm;
    req_t s;
    gm = model_grant();
    @(negedge clk);
    last_ready0 = req0_ready;
    last_ready1 = req1_ready;
    chk("ready0", req0_ready, gm == 0);
    chk("ready1", req1_ready, gm == 1);
    if (gm >= 0) begin
      s = (gm == 1) ? r1 : r0;
      chk("mem_wEn", mem_wEn, s.wen && legal(s));
      chk("mem_addr", mem_addr, s.addr);
      chk("mem_size", mem_size, s.size);
      if (s.wen && legal(s)) chk("mem_wData", mem_wData, s.wdata);
    end else begin
      chk("idle_wEn", mem_wEn, 0);
      chk("idle_addr", mem_addr, 0);
      chk("idle_wData", mem_wData, 0);
    end
    chk("rsp0_valid", rsp0_valid, exp_v[0]);
    if (exp_v[0]) begin
      chk("rsp0_rdata", rsp0_rdata, exp_d[0]);
      chk("rsp0_err", rsp0_err, exp_e[0]);
    end
    chk("rsp1_valid", rsp1_valid, exp_v[1]);
    if (exp_v[1]) begin
      chk("rsp1_rdata", rsp1_rdata, exp_d[1]);
      chk("rsp1_err", rsp1_err, exp_e[1]);
    end
    model_commit(gm);
    @(posedge clk);
    #1;
    g = gm;
  endtask

  function automatic req_t rand_req();
    req_t r;
    int   k;
    r.valid = ($urandom_range(3) != 0);
    k = $urandom_range(9);
    if (k < 7)      r.addr = 32'($urandom_range(63));
    else if (k < 9) r.addr = 32'(MEM_BYTES - 1 - $urandom_range(7));
    else            r.addr = $urandom;
    r.size  = 3'($urandom_range(7));
    r.wen   = 1'($urandom_range(1));
    r.wdata = $urandom;
    r.lock  = ($urandom_range(3) == 0);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   g;
    int   n;
    int   diff;
    req_t idle;
    req_t q1[$];
    logic hist0 [8];
    logic hist1 [8];

    idle = mk(0, 0, 0, 0, 0, 0);
    r0 = idle;
    r1 = idle;
    for (int i = 0; i < int'(MEM_BYTES); i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem[16'h10] = 8'h11; mem[16'h11] = 8'h22; mem[16'h12] = 8'h33; mem[16'h13] = 8'h44;
    mem[16'h30] = 8'h5A;
    for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = mem[i];
    model_reset();

    // reset state
    rst = 1'b1;
    #1;
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_rdata", rsp0_rdata, 0);
    chk("rst_rsp1_rdata", rsp1_rdata, 0);
    chk("rst_rsp0_err", rsp0_err, 0);
    chk("rst_rsp1_err", rsp1_err, 0);
    chk("rst_mem_wEn", mem_wEn, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // both ports load word 0x10: port 0 first, port 1 next cycle
    r0 = mk(1, 32'h10, 3'b010, 0, 0, 0);
    r1 = mk(1, 32'h10, 3'b010, 0, 0, 0);
    step(g);
    chk("tie_rsp0_valid", rsp0_valid, 1);
    chk("tie_rsp1_valid", rsp1_valid, 0);
    chk("tie_rsp0_rdata", rsp0_rdata, 32'h44332211);
    r0 = idle;
    step(g);
    chk("tie_rsp1_valid2", rsp1_valid, 1);
    chk("tie_rsp1_rdata", rsp1_rdata, 32'h44332211);
    chk("tie_rsp0_valid2", rsp0_valid, 0);
    r1 = idle;
    step(g);

    // store half then signed half load back-to-back
    r0 = mk(1, 32'h21, 3'b001, 1, 32'h0000BEEF, 0);
    step(g);
    chk("st_rsp0_valid", rsp0_valid, 1);
    chk("st_rsp0_rdata", rsp0_rdata, 0);
    r0 = mk(1, 32'h21, 3'b101, 0, 0, 0);
    step(g);
    chk("lhs_rsp0_valid", rsp0_valid, 1);
    chk("lhs_rsp0_rdata", rsp0_rdata, 32'hFFFFBEEF);
    chk("st_mem21", mem[16'h21], 8'hEF);
    chk("st_mem22", mem[16'h22], 8'hBE);
    r0 = idle;

    // out-of-range word load and signed-size store
    r1 = mk(1, 32'hFFE, 3'b010, 0, 0, 0);
    step(g);
    chk("oor_rsp1_err", rsp1_err, 1);
    chk("oor_rsp1_rdata", rsp1_rdata, 32'hDEADC0DE);
    r1 = mk(1, 32'h30, 3'b100, 1, 32'h12345678, 0);
    step(g);
    chk("bad_st_err", rsp1_err, 1);
    chk("bad_st_rdata", rsp1_rdata, 32'hDEADC0DE);
    chk("bad_st_mem30", mem[16'h30], 8'h5A);
    r1 = idle;
    step(g);

    // lock sequence: port 1 issues three stores (lock,lock,unlock), port 0 always pending
    q1.push_back(mk(1, 32'h40, 3'b010, 1, 32'hA1A1A1A1, 1));
    q1.push_back(mk(1, 32'h44, 3'b010, 1, 32'hA2A2A2A2, 1));
    q1.push_back(mk(1, 32'h48, 3'b010, 1, 32'hA3A3A3A3, 0));
    n  = 0;
    r1 = q1.pop_front();
    while (n < 7 && r1.valid) begin
      step(g);
      hist0[n] = last_ready0;
      hist1[n] = last_ready1;
      n++;
      if (g == 1) r1 = (q1.size() > 0) ? q1.pop_front() : idle;
      r0 = mk(1, 32'h10, 3'b010, 0, 0, 0);
    end
    step(g);
    hist0[n] = last_ready0;
    hist1[n] = last_ready1;
    n++;
    for (int k = 0; k < n; k++) begin
`ifdef DMEM_ARB_LOCK_EN
      chk($sformatf("lock_ready0_%0d", k), hist0[k], k == 3);
      chk($sformatf("lock_ready1_%0d", k), hist1[k], k < 3);
`else
      chk($sformatf("rr_ready0_%0d", k), hist0[k], k % 2 == 1);
      chk($sformatf("rr_ready1_%0d", k), hist1[k], k % 2 == 0);
`endif
    end
    r0 = idle;
    step(g);

    // randomized traffic against the model
    g = -1;
    for (int c = 0; c < 400; c++) begin
      if (!(r0.valid && g != 0)) r0 = rand_req();
      if (!(r1.valid && g != 1)) r1 = rand_req();
      step(g);
    end

    // release any lock, then drain
    r0 = mk(1, 32'h10, 3'b010, 0, 0, 0);
    r1 = mk(1, 32'h14, 3'b010, 0, 0, 0);
    for (int c = 0; c < 4; c++) step(g);
    r0 = idle;
    r1 = idle;
    step(g);

    // reset right after a load is accepted
    r0 = mk(1, 32'h10, 3'b010, 0, 0, 0);
    step(g);
    r0  = idle;
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp0_valid", rsp0_valid, 0);
    chk("mid_rst_rsp0_rdata", rsp0_rdata, 0);
    chk("mid_rst_rsp0_err", rsp0_err, 0);
    chk("mid_rst_mem_wEn", mem_wEn, 0);
    chk("mid_rst_ready0", req0_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(g);
    step(g);
    // first tie after reset goes to port 0
    r0 = mk(1, 32'h10, 3'b000, 0, 0, 0);
    r1 = mk(1, 32'h11, 3'b000, 0, 0, 0);
    step(g);
    chk("post_rst_rsp0_valid", rsp0_valid, 1);
    r0 = idle;
    step(g);
    r1 = idle;
    step(g);

    diff = 0;
    for (int i = 0; i < int'(MEM_BYTES); i++) if (mem[i] !== ref_mem[i]) diff++;
    chk("mem_image_diffs", diff, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
